// File: rtl/reg_file_p.sv
// Register file with two combinational read ports, one write port, B-port
// immediate expander, optional write-to-read bypass and a post-reset clear sweep.
module reg_file_p #(
  parameter int DW     = 8,
  parameter int PW     = 3,
  parameter int IMW    = 2,
  parameter int BYPASS = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic [PW-1:0] wr_addr,
  input  logic          wr_en,
  input  logic          wr_mov,
  input  logic          b_imm,
  input  logic [IMW-1:0] imm,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          ready,
  output logic          wr_drop
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [DW-1:0] core [2**PW];
  logic [0:0]    state;
  logic [PW-1:0] clr_ptr;
  logic          run;

  logic [DW-1:0] imm_ext;
  logic [DW-1:0] a_raw;
  logic [DW-1:0] b_raw;
  logic [DW-1:0] wr_data;

  assign run   = (state == RUN);
  assign ready = run;

  // Sign-magnitude immediate: sign goes to the MSB, magnitude stays in the LSBs.
  always_comb begin
    imm_ext            = '0;
    imm_ext[DW-1]      = imm[IMW-1];
    imm_ext[IMW-2:0]   = imm[IMW-2:0];
  end

  assign a_raw   = core[rd_addrA];
  assign b_raw   = b_imm ? imm_ext : core[rd_addrB];
  assign wr_data = wr_mov ? b_raw : dat_in;

  // Bypass selects from wr_data, which is built only from un-bypassed reads.
  always_comb begin
    datA_out = '0;
    datB_out = '0;
    if (run) begin
      datA_out = a_raw;
      datB_out = b_raw;
      if (BYPASS != 0 && wr_en) begin
        if (rd_addrA == wr_addr)           datA_out = wr_data;
        if (!b_imm && rd_addrB == wr_addr) datB_out = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && !run;
      if (!run) begin
        core[clr_ptr] <= '0;
        clr_ptr       <= clr_ptr + PW'(1);
        if (clr_ptr == '1) state <= RUN;
      end else if (wr_en) begin
        core[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_p.sv
// Directed self-checking bench for reg_file_p; a bypass-enabled twin shares
// the same stimulus so both read behaviours can be compared to hand values.
module tb_reg_file_p;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rd_addrA, rd_addrB, wr_addr;
  logic       wr_en, wr_mov, b_imm;
  logic [1:0] imm;
  logic [7:0] dat_in;
  logic [7:0] datA_out, datB_out, datA_bp, datB_bp;
  logic       ready, wr_drop, ready_bp, wr_drop_bp;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  reg_file_p #(.DW(8), .PW(3), .IMW(2), .BYPASS(0)) dut (
    .clk(clk), .reset(reset), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_mov(wr_mov), .b_imm(b_imm),
    .imm(imm), .dat_in(dat_in), .datA_out(datA_out), .datB_out(datB_out),
    .ready(ready), .wr_drop(wr_drop)
  );

  reg_file_p #(.DW(8), .PW(3), .IMW(2), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_mov(wr_mov), .b_imm(b_imm),
    .imm(imm), .dat_in(dat_in), .datA_out(datA_bp), .datB_out(datB_bp),
    .ready(ready_bp), .wr_drop(wr_drop_bp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_mov = 1'b0; wr_addr = a; dat_in = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addrA = 3'(i);
      rd_addrB = 3'(7 - i);
      #1;
      check({tag, "_A"}, {24'd0, datA_out}, 32'h00);
      check({tag, "_B"}, {24'd0, datB_out}, 32'h00);
    end
  endtask

  task automatic sweep_checks(input string tag, input bit drop_test);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (drop_test && k == 1) begin
        wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'hFF;
      end
      if (drop_test && k == 2) begin
        check("drop_pulse", {31'd0, wr_drop}, 32'd1);
        wr_en = 1'b0;
      end
      if (drop_test && k == 3) check("drop_end", {31'd0, wr_drop}, 32'd0);
      if (k == 4) begin
        b_imm = 1'b1; imm = 2'b11; rd_addrA = 3'd5;
        #1;
        check({tag, "_gateA"}, {24'd0, datA_out}, 32'h00);
        check({tag, "_gateB_imm"}, {24'd0, datB_out}, 32'h00);
        b_imm = 1'b0;
      end
      check({tag, "_ready"}, {31'd0, ready}, (k == 8) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rd_addrA = '0; rd_addrB = '0; wr_addr = '0;
    wr_en = 1'b0; wr_mov = 1'b0; b_imm = 1'b0; imm = '0; dat_in = '0;

    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_datA", {24'd0, datA_out}, 32'h00);
    reset = 1'b0;

    sweep_checks("sweep1", 1'b1);
    check_all_zero("clear1");

    // Same-cycle write/read: old value without bypass, new value with it.
    rd_addrA = 3'd3; rd_addrB = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'h5A;
    #1;
    check("nobp_same_cycle", {24'd0, datA_out}, 32'h00);
    check("bp_same_cycle", {24'd0, datA_bp}, 32'h5A);
    step();
    wr_en = 1'b0;
    #1;
    check("nobp_after_edge", {24'd0, datA_out}, 32'h5A);
    check("run_no_drop", {31'd0, wr_drop}, 32'd0);

    wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'h11;
    #1;
    check("nobp_B_same_cycle", {24'd0, datB_out}, 32'h00);
    check("bp_B_same_cycle", {24'd0, datB_bp}, 32'h11);
    step();
    wr_en = 1'b0;

    b_imm = 1'b1;
    imm = 2'b00; #1; check("imm00", {24'd0, datB_out}, 32'h00);
    imm = 2'b01; #1; check("imm01", {24'd0, datB_out}, 32'h01);
    imm = 2'b10; #1; check("imm10", {24'd0, datB_out}, 32'h80);
    imm = 2'b11; #1; check("imm11", {24'd0, datB_out}, 32'h81);
    wr_mov = 1'b1; wr_en = 1'b1; wr_addr = 3'd5;
    step();
    wr_en = 1'b0; wr_mov = 1'b0; b_imm = 1'b0; rd_addrA = 3'd5;
    #1;
    check("imm_mov_r5", {24'd0, datA_out}, 32'h81);

    write_reg(3'd2, 8'h3C);
    wr_mov = 1'b1; wr_en = 1'b1; rd_addrB = 3'd2; wr_addr = 3'd6;
    step();
    wr_en = 1'b0; wr_mov = 1'b0; rd_addrA = 3'd6; rd_addrB = 3'd2;
    #1;
    check("move_r6", {24'd0, datA_out}, 32'h3C);
    check("move_r2_kept", {24'd0, datB_out}, 32'h3C);

    write_reg(3'd7, 8'h01);
    write_reg(3'd7, 8'h02);
    rd_addrA = 3'd7;
    #1;
    check("last_write_wins", {24'd0, datA_out}, 32'h02);

    for (int i = 0; i < 8; i++) write_reg(3'(i), 8'(8'h10 + i));
    rd_addrA = 3'd0; rd_addrB = 3'd6;
    #1;
    check("fill_r0", {24'd0, datA_out}, 32'h10);
    check("fill_r6", {24'd0, datB_out}, 32'h16);

    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_run_ready", {31'd0, ready}, 32'd0);
    check("rst_run_gate", {24'd0, datA_out}, 32'h00);
    for (int k = 0; k < 4; k++) step();
    check("midsweep_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_checks("sweep2", 1'b0);
    check_all_zero("clear2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
